// File: rtl/add_tree_op_dist_pkg.sv
// add_tree_op_dist_pkg
// Shared types and constants for the adder-tree operand distributor.
// Provides the pipeline word type carried on the serial input and on
// each operand lane, the lane count and word width of the adder tree,
// and the distributor FSM state encoding.
package add_tree_op_dist_pkg;

  // Number of operand lanes feeding the adder tree
  localparam int C_ADD_TREE_OP_CNT = 4;

  // Arithmetic word width and data-type tag width
  localparam int WORD_WDT = 16;
  localparam int TYPE_WDT = 2;

  // One pipeline word: qualifier, end-of-stream marker, type tag and payload
  typedef struct packed {
    logic                data_val;
    logic                data_last;
    logic [TYPE_WDT-1:0] data_type;
    logic [WORD_WDT-1:0] data_word;
  } pipe_data_t;

  // FILL collects serial words into lanes, EMIT presents the packed vector
  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } add_tree_dist_state_t;

endpackage

// File: rtl/add_tree_op_dist_if.sv
// add_tree_op_dist_if
// Bundles the serial input handshake and the parallel operand output of
// the distributor.
//   in_data      : serial pipeline word (data_val qualifies it)
//   in_rdy       : distributor can take the serial word
//   out_data     : packed operand vector, one pipeline word per lane
//   out_rdy      : adder tree accepts the vector
//   out_lane_msk : per lane, 1 = real word, 0 = zero padding
// master = upstream serializer plus downstream adder tree side,
// slave  = the distributor itself.
interface add_tree_op_dist_if
  import add_tree_op_dist_pkg::*;
#(
  parameter int OP_CNT = C_ADD_TREE_OP_CNT
);

  pipe_data_t                in_data;
  logic                      in_rdy;
  pipe_data_t [OP_CNT-1:0]   out_data;
  logic                      out_rdy;
  logic       [OP_CNT-1:0]   out_lane_msk;

  modport master (
    output in_data,
    output out_rdy,
    input  in_rdy,
    input  out_data,
    input  out_lane_msk
  );

  modport slave (
    input  in_data,
    input  out_rdy,
    output in_rdy,
    output out_data,
    output out_lane_msk
  );

endinterface

// File: rtl/add_tree_op_dist.sv
// add_tree_op_dist
// Serial-to-parallel operand distributor placed between the systolic-array
// output serializer and the adder tree. Serial words are packed into an
// OP_CNT-lane operand vector; a vector closes when it is full, when a word
// carries data_last, or when the next word has a different data_type.
// Short vectors are zero padded and flagged through out_lane_msk.
// Ports:
//   clk    : clock
//   rst    : synchronous reset, active high
//   clk_en : global enable, low freezes all state and blocks transfers
//   bus    : slave modport of add_tree_op_dist_if (serial in, vector out)
module add_tree_op_dist
  import add_tree_op_dist_pkg::*;
#(
  parameter int OP_CNT = C_ADD_TREE_OP_CNT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  add_tree_op_dist_if.slave  bus
);

  localparam int CNT_W = $clog2(OP_CNT + 1);

  add_tree_dist_state_t             state;
  add_tree_dist_state_t             state_nxt;
  logic [CNT_W-1:0]                 lane_cnt;
  logic [CNT_W-1:0]                 lane_cnt_inc;
  logic [TYPE_WDT-1:0]              type_reg;
  logic [OP_CNT-1:0][WORD_WDT-1:0]  lane_word;
  logic [OP_CNT-1:0]                msk;
  logic                             last_reg;

  logic type_chg;
  logic in_rdy;
  logic in_xfer;
  logic out_xfer;
  logic fill_done;
  logic close_vec;

  // A word of a different type may not join a partial vector. Detecting it
  // combinationally lets in_rdy drop in the same cycle so the word is held
  // upstream and starts the next vector.
  assign type_chg = (lane_cnt != '0) && bus.in_data.data_val &&
                    (bus.in_data.data_type != type_reg);

  assign in_rdy     = (state == FILL) && !rst && !type_chg;
  assign bus.in_rdy = in_rdy;

  assign in_xfer      = bus.in_data.data_val && in_rdy && clk_en;
  assign out_xfer     = (state == EMIT) && bus.out_rdy && clk_en;
  assign lane_cnt_inc = lane_cnt + CNT_W'(1);

  // Accepted word either fills the last lane or terminates the stream
  assign fill_done = (lane_cnt_inc == CNT_W'(OP_CNT)) || bus.in_data.data_last;

  assign close_vec = (in_xfer && fill_done) ||
                     ((state == FILL) && clk_en && type_chg);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (close_vec) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (out_xfer) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Lane register file, fill counter and vector side-channel. Lanes are
  // wiped after each output transfer so a later short vector is padded
  // with zeros rather than stale words.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt  <= '0;
      type_reg  <= '0;
      lane_word <= '0;
      msk       <= '0;
      last_reg  <= 1'b0;
    end else begin
      if (in_xfer) begin
        for (int i = 0; i < OP_CNT; i++) begin
          if (lane_cnt == CNT_W'(i)) begin
            lane_word[i] <= bus.in_data.data_word;
            msk[i]       <= 1'b1;
          end
        end
        if (lane_cnt == '0) begin
          type_reg <= bus.in_data.data_type;
        end
        lane_cnt <= fill_done ? '0 : lane_cnt_inc;
        last_reg <= bus.in_data.data_last;
      end else if (close_vec) begin
        // Closed by a type change: the vector is not a stream end
        lane_cnt <= '0;
        last_reg <= 1'b0;
      end
      if (out_xfer) begin
        lane_word <= '0;
        msk       <= '0;
        last_reg  <= 1'b0;
      end
    end
  end

  // Output vector is only visible in EMIT; during FILL every field reads 0
  always_comb begin
    bus.out_data     = '0;
    bus.out_lane_msk = '0;
    if (state == EMIT) begin
      bus.out_lane_msk = msk;
      for (int i = 0; i < OP_CNT; i++) begin
        bus.out_data[i].data_val  = 1'b1;
        bus.out_data[i].data_last = last_reg;
        bus.out_data[i].data_type = type_reg;
        bus.out_data[i].data_word = lane_word[i];
      end
    end
  end

endmodule
